// File: rtl/vec_lsu_pkg.sv
// Shared types and helpers for the strided vector load/store unit.
// Element width codes, FSM state encoding and lane strobe/mask helpers.
package vec_lsu_pkg;

    typedef enum logic [1:0] {
        SEW_8   = 2'd0,
        SEW_16  = 2'd1,
        SEW_32  = 2'd2,
        SEW_BAD = 2'd3
    } sew_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_REQ  = 3'd2,
        ST_WB   = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Byte strobes covering one element placed at byte offset off of a word.
    function automatic logic [3:0] wstrb_for(input logic [1:0] sew, input logic [1:0] off);
        case (sew)
            SEW_8:   return 4'b0001 << off;
            SEW_16:  return off[1] ? 4'b1100 : 4'b0011;
            SEW_32:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] elem_mask(input logic [1:0] sew);
        case (sew)
            SEW_8:   return 32'h0000_00FF;
            SEW_16:  return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Illegal width counts as misaligned so a single check aborts the command.
    function automatic logic is_misaligned(input logic [1:0] sew, input logic [1:0] off);
        case (sew)
            SEW_8:   return 1'b0;
            SEW_16:  return off[0];
            SEW_32:  return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/vec_lsu_lane_align.sv
// Combinational lane steering between a 32-bit memory word and one vector element.
// Loads shift the addressed lane down and mask it; stores replicate and strobe it.
module vec_lsu_lane_align
    import vec_lsu_pkg::*;
(
    input  logic [1:0]  sew,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] st_elem,
    output logic [31:0] ld_elem,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        ld_elem  = shifted & elem_mask(sew);
        case (sew)
            SEW_8:   st_wdata = {4{st_elem[7:0]}};
            SEW_16:  st_wdata = {2{st_elem[15:0]}};
            default: st_wdata = st_elem;
        endcase
        st_wstrb = wstrb_for(sew, offset);
    end

endmodule

// File: rtl/vec_lsu_strided.sv
// Strided vector load/store initiator: one word access per element on a mem_valid/mem_ready bus.
// Optional VEC_LSU_COALESCE_EN reuses the last loaded word when consecutive elements share it.
module vec_lsu_strided
    import vec_lsu_pkg::*;
#(
    parameter int VL_MAX = 32,
    parameter int IDXW   = 5
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_store,
    input  logic [31:0]     cmd_base,
    input  logic [31:0]     cmd_stride,
    input  logic [1:0]      cmd_sew,
    input  logic [IDXW:0]   cmd_vl,
    output logic            done,
    output logic            err,
    output logic            ld_we,
    output logic [IDXW-1:0] ld_idx,
    output logic [31:0]     ld_data,
    output logic [IDXW-1:0] st_idx,
    input  logic [31:0]     st_data,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [31:0]     mem_rdata
);

    localparam logic [IDXW:0] VL_CAP = (IDXW+1)'(VL_MAX);

    state_t          state;
    logic            store_reg;
    logic [1:0]      sew_reg;
    logic [31:0]     ea_reg;
    logic [31:0]     stride_reg;
    logic [IDXW:0]   vl_reg;
    logic [IDXW-1:0] idx_reg;

    logic [IDXW:0]   vl_clamped;
    logic            last_elem;
    logic [31:0]     lane_src;
    logic [31:0]     lane_ld;
    logic [31:0]     lane_wdata;
    logic [3:0]      lane_wstrb;

    assign vl_clamped = (cmd_vl > VL_CAP) ? VL_CAP : cmd_vl;
    assign last_elem  = ({1'b0, idx_reg} == (vl_reg - 1'b1));
    assign st_idx     = idx_reg;

`ifdef VEC_LSU_COALESCE_EN
    logic        tag_valid;
    logic [29:0] tag_addr;
    logic [31:0] tag_data;
    logic        tag_hit;

    assign tag_hit  = !store_reg && tag_valid && (tag_addr == ea_reg[31:2]);
    // The cached word is only consumed in CALC; REQ always aligns the live bus data.
    assign lane_src = (state == ST_CALC) ? tag_data : mem_rdata;
`else
    assign lane_src = mem_rdata;
`endif

    vec_lsu_lane_align u_align (
        .sew      (sew_reg),
        .offset   (ea_reg[1:0]),
        .rdata    (lane_src),
        .st_elem  (st_data),
        .ld_elem  (lane_ld),
        .st_wdata (lane_wdata),
        .st_wstrb (lane_wstrb)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            ld_we      <= 1'b0;
            ld_idx     <= '0;
            ld_data    <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            store_reg  <= 1'b0;
            sew_reg    <= '0;
            ea_reg     <= '0;
            stride_reg <= '0;
            vl_reg     <= '0;
            idx_reg    <= '0;
`ifdef VEC_LSU_COALESCE_EN
            tag_valid  <= 1'b0;
            tag_addr   <= '0;
            tag_data   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        store_reg  <= cmd_store;
                        sew_reg    <= cmd_sew;
                        ea_reg     <= cmd_base;
                        stride_reg <= cmd_stride;
                        vl_reg     <= vl_clamped;
                        idx_reg    <= '0;
                        cmd_ready  <= 1'b0;
                        err        <= 1'b0;
`ifdef VEC_LSU_COALESCE_EN
                        tag_valid  <= 1'b0;
`endif
                        if (vl_clamped == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (is_misaligned(sew_reg, ea_reg[1:0])) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
`ifdef VEC_LSU_COALESCE_EN
                    else if (tag_hit) begin
                        ld_we   <= 1'b1;
                        ld_idx  <= idx_reg;
                        ld_data <= lane_ld;
                        state   <= ST_WB;
                    end
`endif
                    else begin
                        mem_valid <= 1'b1;
                        mem_addr  <= {ea_reg[31:2], 2'b00};
                        mem_wdata <= store_reg ? lane_wdata : 32'h0;
                        mem_wstrb <= store_reg ? lane_wstrb : 4'b0000;
`ifdef VEC_LSU_COALESCE_EN
                        if (store_reg) begin
                            tag_valid <= 1'b0;
                        end
`endif
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        if (store_reg) begin
                            state <= ST_NEXT;
                        end else begin
                            ld_we   <= 1'b1;
                            ld_idx  <= idx_reg;
                            ld_data <= lane_ld;
`ifdef VEC_LSU_COALESCE_EN
                            tag_valid <= 1'b1;
                            tag_addr  <= ea_reg[31:2];
                            tag_data  <= mem_rdata;
`endif
                            state   <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    ld_we <= 1'b0;
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    // Running sum equals base + idx*stride modulo 2^32.
                    idx_reg <= idx_reg + 1'b1;
                    ea_reg  <= ea_reg + stride_reg;
                    if (last_elem) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_lsu_strided.sv
// Scoreboard bench for vec_lsu_strided: a word-level reference model queues expected
// requests, load writebacks and completions; monitors compare as the DUT produces them.
module tb_vec_lsu_strided;

    localparam int VL_MAX = 32;
    localparam int IDXW   = 5;
`ifdef VEC_LSU_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_store;
    logic [31:0]     cmd_base;
    logic [31:0]     cmd_stride;
    logic [1:0]      cmd_sew;
    logic [IDXW:0]   cmd_vl;
    logic            done;
    logic            err;
    logic            ld_we;
    logic [IDXW-1:0] ld_idx;
    logic [31:0]     ld_data;
    logic [IDXW-1:0] st_idx;
    logic [31:0]     st_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic [31:0]     mem_rdata;

    vec_lsu_strided #(.VL_MAX(VL_MAX), .IDXW(IDXW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_store  (cmd_store),
        .cmd_base   (cmd_base),
        .cmd_stride (cmd_stride),
        .cmd_sew    (cmd_sew),
        .cmd_vl     (cmd_vl),
        .done       (done),
        .err        (err),
        .ld_we      (ld_we),
        .ld_idx     (ld_idx),
        .ld_data    (ld_data),
        .st_idx     (st_idx),
        .st_data    (st_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] vrf     [0:31];
    assign st_data = vrf[st_idx];

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } ld_t;

    req_t exp_req[$];
    ld_t  exp_ld[$];
    logic exp_err[$];

    int tests = 0;
    int fails = 0;
    int req_count = 0;
    int ld_count = 0;
    int done_count = 0;
    int stall_mode = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: element i lives at base + i*stride; stores update ref_mem bytewise.
    function automatic void model_cmd(input logic st, input logic [31:0] base,
                                      input logic [31:0] stride, input logic [1:0] sew,
                                      input int vl);
        int          n;
        int          bytes;
        int          off;
        logic [31:0] ea;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] elem;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        have_tag;
        logic [29:0] tag;
        logic        e_err;
        n        = (vl > VL_MAX) ? VL_MAX : vl;
        bytes    = (sew == 2'd0) ? 1 : (sew == 2'd1) ? 2 : 4;
        mask     = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 32'd1);
        have_tag = 1'b0;
        tag      = '0;
        e_err    = 1'b0;
        for (int i = 0; i < n; i++) begin
            ea  = base + 32'(i) * stride;
            off = int'(ea[1:0]);
            if (sew == 2'd3 || (off % bytes) != 0) begin
                e_err = 1'b1;
                break;
            end
            if (!st) begin
                word = ref_mem[ea[11:2]];
                if (!(COALESCE && have_tag && tag == ea[31:2]))
                    exp_req.push_back('{addr: {ea[31:2], 2'b00}, write: 1'b0, wstrb: 4'b0000, wdata: 32'h0});
                have_tag = 1'b1;
                tag      = ea[31:2];
                elem     = (word >> (8 * off)) & mask;
                exp_ld.push_back('{idx: 5'(i), data: elem});
            end else begin
                elem  = vrf[i] & mask;
                wdata = '0;
                for (int k = 0; k < 4; k += bytes) wdata = wdata | (elem << (8 * k));
                wstrb = '0;
                for (int j = 0; j < bytes; j++) wstrb[off + j] = 1'b1;
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) ref_mem[ea[11:2]][8*b +: 8] = wdata[8*b +: 8];
                exp_req.push_back('{addr: {ea[31:2], 2'b00}, write: 1'b1, wstrb: wstrb, wdata: wdata});
            end
        end
        exp_err.push_back(e_err);
    endfunction

    // Memory responder with configurable stall; also checks request content and hold stability.
    initial begin
        logic        in_req;
        int          wait_cnt;
        logic [31:0] hold_addr;
        logic [31:0] hold_wdata;
        logic [3:0]  hold_wstrb;
        req_t        e;
        in_req    = 1'b0;
        wait_cnt  = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mem_ready = 1'b0;
                in_req    = 1'b0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_valid) begin
                if (!in_req) begin
                    in_req     = 1'b1;
                    hold_addr  = mem_addr;
                    hold_wdata = mem_wdata;
                    hold_wstrb = mem_wstrb;
                    req_count++;
                    wait_cnt   = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
                    if (exp_req.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_req: got addr 0x%08h expected no request", mem_addr);
                    end else begin
                        e = exp_req.pop_front();
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
                        if (e.write) check("mem_wdata", mem_wdata, e.wdata);
                    end
                end else begin
                    check("hold_addr", mem_addr, hold_addr);
                    check("hold_wdata", mem_wdata, hold_wdata);
                    check("hold_wstrb", {28'h0, mem_wstrb}, {28'h0, hold_wstrb});
                end
                if (wait_cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[11:2]];
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    in_req = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Load writeback monitor.
    initial begin
        ld_t e;
        forever begin
            @(negedge clk);
            if (resetn && ld_we) begin
                ld_count++;
                if (exp_ld.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ld_we: got idx %0d expected no write", ld_idx);
                end else begin
                    e = exp_ld.pop_front();
                    check("ld_idx", {27'h0, ld_idx}, {27'h0, e.idx});
                    check("ld_data", ld_data, e.data);
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            if (resetn && done) begin
                done_count++;
                if (exp_err.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    e = exp_err.pop_front();
                    check("done_err", {31'h0, err}, {31'h0, e});
                end
            end
        end
    end

    task automatic run_cmd(input logic st, input logic [31:0] base, input logic [31:0] stride,
                           input logic [1:0] sew, input int vl, output int lat);
        int start;
        model_cmd(st, base, stride, sew, vl);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_store  = st;
        cmd_base   = base;
        cmd_stride = stride;
        cmd_sew    = sew;
        cmd_vl     = (IDXW+1)'(vl);
        start      = done_count;
        lat        = 0;
        while (done_count == start && lat < 3000) begin
            @(negedge clk);
            #1;
            lat++;
            cmd_valid = 1'b0;
        end
        if (done_count == start) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
        end
        tests++;
        if (exp_req.size() != 0 || exp_ld.size() != 0 || exp_err.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d req %0d ld %0d done pending expected 0",
                     exp_req.size(), exp_ld.size(), exp_err.size());
            exp_req.delete();
            exp_ld.delete();
            exp_err.delete();
        end
        $display("[TB] %s sew=%0d base=0x%08h stride=%0d vl=%0d cycles=%0d",
                 st ? "store" : "load ", sew, base, $signed(stride), vl, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0;
        int l0;
        int k;
        int mism;
        logic        st;
        logic [1:0]  sew;
        int          bytes;
        logic [31:0] base;
        logic [31:0] stride;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 32; i++) vrf[i] = $urandom;
        resetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_store = 1'b0;
        cmd_base = '0;
        cmd_stride = '0;
        cmd_sew = '0;
        cmd_vl = '0;

        @(negedge clk);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
        check("rst_mem_valid", {31'h0, mem_valid}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_err", {31'h0, err}, 32'd0);
        check("rst_ld_we", {31'h0, ld_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Halfword load across two words.
        mem[100] = 32'h0403_0201; ref_mem[100] = mem[100];
        mem[101] = 32'h0807_0605; ref_mem[101] = mem[101];
        r0 = req_count;
        run_cmd(1'b0, 32'd400, 32'd2, 2'd1, 4, lat);
        check("sew16_req_count", 32'(req_count - r0), COALESCE ? 32'd2 : 32'd4);

        // Byte store into one word.
        vrf[0] = 32'h0000_00A1; vrf[1] = 32'h0000_00A2; vrf[2] = 32'h0000_00A3; vrf[3] = 32'h0000_00A4;
        run_cmd(1'b1, 32'd800, 32'd1, 2'd0, 4, lat);
        check("store_mem200", mem[200], 32'hA4A3_A2A1);

        // Negative stride word load.
        run_cmd(1'b0, 32'd412, 32'hFFFF_FFFC, 2'd2, 3, lat);

        // Empty command completes one cycle after accept with no traffic.
        r0 = req_count;
        run_cmd(1'b0, 32'd0, 32'd4, 2'd2, 0, lat);
        check("vl0_latency", 32'(lat), 32'd1);
        check("vl0_req_count", 32'(req_count - r0), 32'd0);

        // Misaligned word and illegal width abort before any access.
        r0 = req_count; l0 = ld_count;
        run_cmd(1'b0, 32'd402, 32'd4, 2'd2, 2, lat);
        check("misalign_req_count", 32'(req_count - r0), 32'd0);
        check("misalign_ld_count", 32'(ld_count - l0), 32'd0);
        r0 = req_count; l0 = ld_count;
        run_cmd(1'b0, 32'd400, 32'd4, 2'd3, 2, lat);
        check("sew3_req_count", 32'(req_count - r0), 32'd0);
        check("sew3_ld_count", 32'(ld_count - l0), 32'd0);

        // Long responder stalls; the responder checks hold stability each stalled cycle.
        stall_mode = 5;
        run_cmd(1'b1, 32'd1000, 32'd2, 2'd1, 3, lat);
        run_cmd(1'b0, 32'd996, 32'd3, 2'd0, 3, lat);
        stall_mode = -1;

        // Reset in the middle of an outstanding request.
        stall_mode = 10;
        model_cmd(1'b0, 32'd64, 32'd4, 2'd2, 4);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_store = 1'b0; cmd_base = 32'd64; cmd_stride = 32'd4;
        cmd_sew = 2'd2; cmd_vl = 6'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!mem_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rst_test_req_seen", {31'h0, mem_valid}, 32'd1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_mem_valid", {31'h0, mem_valid}, 32'd0);
        check("async_rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
        repeat (3) @(negedge clk);
        exp_req.delete();
        exp_ld.delete();
        exp_err.delete();
        resetn = 1'b1;
        stall_mode = -1;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
        run_cmd(1'b0, 32'd400, 32'd2, 2'd1, 4, lat);

        // Randomized mix of loads and stores.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 32; i++) vrf[i] = $urandom;
            st    = 1'($urandom_range(0, 1));
            sew   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            bytes = (sew == 2'd0) ? 1 : (sew == 2'd1) ? 2 : 4;
            base  = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) != 0) base = base & ~(32'(bytes) - 32'd1);
            if ($urandom_range(0, 7) != 0)
                stride = 32'(bytes * ($signed($urandom_range(0, 8)) - 4));
            else
                stride = 32'($signed($urandom_range(0, 14)) - 7);
            run_cmd(st, base, stride, sew, int'($urandom_range(0, 34)), lat);
        end

        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("final_mem_mismatch_words", 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vec_lsu_strided.md
Name: vec_lsu_strided

Overview:
- Initiator side of the vector coprocessor memory interface: executes one strided vector load (vlse) or strided store (vsse) per command.
- Issues one word access per element on the picorv32-style mem_valid/mem_ready bus.
- Load elements are written into the vector register file. Store elements are fetched from it.
- Sits between the picorv32_pcpi_vec decode/control logic and the shared memory responder.

Parameters:
- VL_MAX, 32, maximum elements per command (vl is saturated to this value)
- IDXW, 5, element index width; equals $clog2(VL_MAX)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_store  in  1  1 = vsse, 0 = vlse
- cmd_base  in  32  byte base address (cpu rs1)
- cmd_stride  in  32  signed byte stride (cpu rs2)
- cmd_sew  in  2  0 = 8b, 1 = 16b, 2 = 32b, 3 = illegal
- cmd_vl  in  IDXW+1  element count
- done  out  1  one-cycle pulse when a command completes
- err  out  1  valid with done; misaligned element or illegal SEW
- ld_we  out  1  load element write strobe
- ld_idx  out  IDXW  load element index
- ld_data  out  32  zero-extended load element
- st_idx  out  IDXW  store element index
- st_data  in  32  element at st_idx, combinational, low SEW bits used
- mem_valid  out  1  memory request
- mem_ready  in  1  one-cycle accept/return pulse
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  store data
- mem_wstrb  out  4  0 for reads
- mem_rdata  in  32  read data, valid with mem_ready

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. Reset is asynchronous; mem_valid drops in the same instant, mid-request included. A pending command is discarded.
- State IDLE:
  - cmd_valid & cmd_ready latches base, stride, sew, vl and clears idx, then goes to CALC.
  - vl = 0 goes to DONE instead.
  - cmd_vl > VL_MAX is clamped to VL_MAX.
- State CALC: computes ea = base + idx*stride, 32-bit wrap-around, stride sign-extended.
  - Illegal SEW, ea[0] set for 16b, or ea[1:0] nonzero for 32b sets err and goes to DONE. Elements already completed stay written.
  - Otherwise goes to REQ.
- State REQ:
  - mem_valid = 1 and mem_addr = {ea[31:2], 2'b00}.
  - mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready.
  - Store: wdata is the element replicated across lanes (8b x4, 16b x2); wstrb covers the element bytes at ea[1:0] (8b: 1<<ea[1:0]; 16b: 0011 or 1100; 32b: 1111).
  - On mem_ready, mem_valid deasserts the next cycle.
  - Load goes to WB; store goes to NEXT.
- State WB: ld_we = 1 for one cycle; ld_data = rdata shifted right by 8*ea[1:0], masked to SEW. Then goes to NEXT.
- State NEXT: idx increments. If idx = vl-1 goes to DONE, else to CALC.
- State DONE: done = 1 for one cycle, then IDLE.
- Latency per element: 2 cycles plus memory latency (load +1 for WB). With a one-cycle-latency responder, a load costs 4 cycles per element.
- st_idx = idx at all times.
- A stride of 0 repeatedly accesses the same element.
- cmd_valid while busy is ignored, since cmd_ready = 0.

Optional Feature:
- Macro: VEC_LSU_COALESCE_EN
- Defined:
  - Loads keep the last word address and data in a tag register.
  - When CALC finds the same word address and the tag is valid, the FSM skips REQ and goes straight to WB using the cached word.
  - The tag is invalidated at command start, on reset, and by any store.
- Undefined: every element issues its own memory request.

Decomposition:
- Package vec_lsu_pkg holds:
  - SEW codes
  - FSM state encoding (IDLE, CALC, REQ, WB, NEXT, DONE)
  - a function mapping SEW/offset to wstrb
  - a function mapping SEW to element mask
- One natural sub-module: vec_lsu_lane_align, which is combinational. Load direction: shift and mask. Store direction: replicate and strobe.

Test Plan:
- Load, sew16, base 400, stride 2, vl 4, mem[100] = 0x04030201, mem[101] = 0x08070605.
  - ld_data = 0x0201, 0x0403, 0x0605, 0x0807 at idx 0-3.
  - 4 requests without coalescing; 2 with VEC_LSU_COALESCE_EN.
  - done with err = 0.
- Store, sew8, base 800, stride 1, vl 4, elements 0xA1..0xA4.
  - Addresses 800 x4.
  - wstrb 0001, 0010, 0100, 1000.
  - wdata 0xA1A1A1A1 to 0xA4A4A4A4.
  - mem[200] = 0xA4A3A2A1.
- Load, sew32, base 412, stride -4, vl 3: addresses 412, 408, 404 in that order. vl = 0: done one cycle after accept, no mem_valid.
- Load, sew32, base 402: err = 1 with done, zero memory requests, no ld_we. Same for sew = 3.
- Responder stalls mem_ready 5 cycles: mem_addr, mem_wdata and mem_wstrb stay constant throughout.
- Deassert resetn mid-REQ: mem_valid = 0 immediately. After release, cmd_ready = 1 and a new command runs correctly.
